studio2_keypad: RTL and testbench
=================================

# studio2_keypad

Dual hexpad front end for the Studio II core. It decodes PS/2 key events into the two 10-key keypads and latches the key-select value the CPU writes with OUT 2. It drives the CPU EF3/EF4 flags: EF3 is high when the selected key is held on keypad 1, and EF4 is high when it is held on keypad 2. It sits between the PS/2 input and the cdp1802 EF/IO ports, replacing the ad-hoc button registers in the top level.

## Interface
- HOLD_W, 20: width of each per-key minimum-hold counter.
- MIN_HOLD, 500000: minimum asserted time in clk cycles after a press; 0 disables stretching. Must fit in HOLD_W bits.
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  PS/2 event bus:
  - [10] toggles once per event.
  - [9] is 1 for press, 0 for release.
  - [8] is the extended flag.
  - [7:0] is the scan code.
- io_out  in  1  CPU output strobe; one cycle per OUT instruction.
- io_n  in  3  CPU N lines (port number).
- io_dout  in  8  CPU output data.
- ef3  out  1  selected key held on keypad 1; active-high, registered.
- ef4  out  1  selected key held on keypad 2; active-high, registered.
- key_sel  out  4  current latched key select (debug/visibility).
- keys1  out  10  keypad 1 key states; bit k is key k.
- keys2  out  10  keypad 2 key states; bit k is key k.

## Operation
- Key map, non-extended codes only (ps2_key[8]=0):
  - Keypad 1, keys 0-9 from the top number row: 45,16,1E,26,25,2E,36,3D,3E,46.
  - Keypad 2, keys 0-9 from the numeric pad: 70,69,72,7A,6B,73,74,6C,75,7D.
  - All other codes and all extended codes are ignored and change no state.
- Event detection:
  - A registered copy old_tog of ps2_key[10] is kept.
  - An event occurs on any cycle where ps2_key[10] != old_tog and primed=1.
  - old_tog is loaded from ps2_key[10] every cycle.
- Priming after reset:
  - The primed flag is 0 while in reset.
  - It is set on the first clk edge after reset deasserts.
  - The toggle level present at reset release therefore never produces an event.
- Per-key state, 20 instances. Each has a held bit, a pend bit (release pending), and a cnt counter of HOLD_W bits.
- Press event on a key:
  - held=1, pend=0, cnt=MIN_HOLD.
  - A repeated press while already held reloads cnt.
- Release event on a key:
  - If cnt==0, held=0 at that edge.
  - Otherwise pend=1 and held stays 1.
- Each cycle with no event for that key:
  - If cnt!=0, cnt decrements by 1.
  - If cnt==0 and pend=1, then held=0 and pend=0.
- Select latch:
  - When io_out=1 and io_n==3'd2, key_sel<=io_dout[3:0].
  - io_dout[7:4] is ignored.
- Flag outputs:
  - ef3<=keys1[key_sel] and ef4<=keys2[key_sel] when key_sel<=9.
  - Both flags are 0 when key_sel is 10-15.
- Reset values: key_sel=0, ef3=0, ef4=0, keys1=0, keys2=0, all cnt=0, all pend=0, old_tog=0, primed=0.
- Reset mid-hold drops every key immediately. Any release arriving after reset is a no-op on a key that is already clear.

## Timing
- Event to keysN:
  - The key state updates on the first clk edge on which ps2_key[10] differs from old_tog.
  - ef3/ef4 follow on the next edge, giving 2 edges total.
- OUT 2 to flag:
  - key_sel updates on the strobe edge.
  - ef3/ef4 reflect the new selection on the following edge.
- Minimum hold:
  - With press at edge P and release at any edge R, held falls at edge max(R, P+MIN_HOLD).
  - If MIN_HOLD=0, held falls at R.
- Simultaneous events:
  - A select write and a key event in the same cycle both take effect.
  - ef reflects both on the next edge.
  - Only one PS/2 event exists per cycle by construction.
- The strobe needs no handshake; io_out must be a single-cycle pulse, and a multi-cycle pulse just relatches the same value.

## Test plan
- Reset with ps2_key[10]=1 held, release reset -> no key asserts; keys1=keys2=0, ef3=ef4=0 for 10 cycles.
- MIN_HOLD=0: OUT 2 with io_dout=8'h05, then toggle press 2E -> keys1[5]=1 one edge later and ef3=1 at the next edge. Release 2E -> ef3=0 two edges after the toggle.
- MIN_HOLD=100: press then release numeric-pad 1 (69) 10 cycles later -> keys2[1] stays high until press+100 edges, then clears. ef4 is high throughout only while key_sel=1.
- Repress during pend (MIN_HOLD=100): press 16 at t0, release at t0+10, press at t0+50, no further release -> keys1[1] stays high indefinitely, with no drop at t0+100.
- OUT 2 with io_dout=8'h0C while keys 0-9 of both pads are held -> ef3=ef4=0. OUT 2 with 8'hF3 -> key_sel=3 and the flags track key 3.
- Extended code E0-70 press, unmapped code 1C press, and OUT on io_n=3 -> no change to keys1/keys2/key_sel. Asserting reset while keys are held clears all outputs asynchronously.

Source files
------------

// File: rtl/studio2_keypad.sv
// Studio II dual hexpad: PS/2 events -> two 10-key pads, OUT 2 key select, EF3/EF4 flags.
// Key state updates on the event edge; flags follow one edge later. No backpressure.
module studio2_keypad #(
   parameter int HOLD_W   = 20,
   parameter int MIN_HOLD = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic        io_out,
   input  logic [2:0]  io_n,
   input  logic [7:0]  io_dout,
   output logic        ef3,
   output logic        ef4,
   output logic [3:0]  key_sel,
   output logic [9:0]  keys1,
   output logic [9:0]  keys2
);

   localparam int NKEY = 20;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HOLD);
   localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);

   logic              old_tog_q;
   logic              primed_q;
   logic [3:0]        sel_q, sel_d;
   logic              ef3_q, ef3_d;
   logic              ef4_q, ef4_d;
   logic [NKEY-1:0]   held_q, held_d;
   logic [NKEY-1:0]   pend_q, pend_d;
   logic [HOLD_W-1:0] cnt_q [NKEY];
   logic [HOLD_W-1:0] cnt_d [NKEY];

   logic              ev;
   logic              code_ok;
   logic              key_hit;
   logic [4:0]        key_idx;
   logic [15:0]       pad1_ext, pad2_ext;
   logic              unused_dout_hi;

   assign unused_dout_hi = ^io_dout[7:4];

   assign ev      = primed_q && (ps2_key[10] != old_tog_q);
   assign key_hit = ev && !ps2_key[8] && code_ok;

   always_comb begin
      code_ok = 1'b1;
      key_idx = 5'd0;
      case (ps2_key[7:0])
         8'h45: key_idx = 5'd0;
         8'h16: key_idx = 5'd1;
         8'h1E: key_idx = 5'd2;
         8'h26: key_idx = 5'd3;
         8'h25: key_idx = 5'd4;
         8'h2E: key_idx = 5'd5;
         8'h36: key_idx = 5'd6;
         8'h3D: key_idx = 5'd7;
         8'h3E: key_idx = 5'd8;
         8'h46: key_idx = 5'd9;
         8'h70: key_idx = 5'd10;
         8'h69: key_idx = 5'd11;
         8'h72: key_idx = 5'd12;
         8'h7A: key_idx = 5'd13;
         8'h6B: key_idx = 5'd14;
         8'h73: key_idx = 5'd15;
         8'h74: key_idx = 5'd16;
         8'h6C: key_idx = 5'd17;
         8'h75: key_idx = 5'd18;
         8'h7D: key_idx = 5'd19;
         default: code_ok = 1'b0;
      endcase
   end

   // The counter runs on every non-press edge (release edges included), so a key
   // whose counter shows 1 is in its last hold cycle: a release there drops it now.
   always_comb begin
      held_d = held_q;
      pend_d = pend_q;
      for (int k = 0; k < NKEY; k++) begin
         cnt_d[k] = cnt_q[k];
         if (key_hit && key_idx == 5'(k)) begin
            if (ps2_key[9]) begin
               held_d[k] = 1'b1;
               pend_d[k] = 1'b0;
               cnt_d[k]  = HOLD_INIT;
            end else if (cnt_q[k] <= CNT_ONE) begin
               held_d[k] = 1'b0;
               pend_d[k] = 1'b0;
               cnt_d[k]  = '0;
            end else begin
               pend_d[k] = 1'b1;
               cnt_d[k]  = cnt_q[k] - CNT_ONE;
            end
         end else begin
            if (cnt_q[k] != '0) begin
               cnt_d[k] = cnt_q[k] - CNT_ONE;
            end
            if (pend_q[k] && cnt_q[k] <= CNT_ONE) begin
               held_d[k] = 1'b0;
               pend_d[k] = 1'b0;
            end
         end
      end
   end

   // Zero-extending to 16 entries makes selects 10-15 read as "not held".
   assign pad1_ext = {6'b0, held_q[9:0]};
   assign pad2_ext = {6'b0, held_q[19:10]};

   always_comb begin
      sel_d = sel_q;
      if (io_out && io_n == 3'd2) begin
         sel_d = io_dout[3:0];
      end
      ef3_d = pad1_ext[sel_q];
      ef4_d = pad2_ext[sel_q];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         old_tog_q <= 1'b0;
         primed_q  <= 1'b0;
         sel_q     <= 4'd0;
         ef3_q     <= 1'b0;
         ef4_q     <= 1'b0;
         held_q    <= '0;
         pend_q    <= '0;
         for (int k = 0; k < NKEY; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         old_tog_q <= ps2_key[10];
         primed_q  <= 1'b1;
         sel_q     <= sel_d;
         ef3_q     <= ef3_d;
         ef4_q     <= ef4_d;
         held_q    <= held_d;
         pend_q    <= pend_d;
         for (int k = 0; k < NKEY; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign ef3     = ef3_q;
   assign ef4     = ef4_q;
   assign key_sel = sel_q;
   assign keys1   = held_q[9:0];
   assign keys2   = held_q[19:10];

endmodule

// File: tb/tb_studio2_keypad.sv
// Bench for studio2_keypad: two instances (MIN_HOLD 0 and 100) share stimulus and
// are checked against a timestamp-based model, a constant vector table and hand sequences.
module tb_studio2_keypad;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic        io_out;
   logic [2:0]  io_n;
   logic [7:0]  io_dout;

   logic       e3_a, e4_a, e3_b, e4_b;
   logic [3:0] sel_a, sel_b;
   logic [9:0] k1_a, k2_a, k1_b, k2_b;

   always #5 clk = ~clk;

   studio2_keypad #(.HOLD_W(20), .MIN_HOLD(0)) dut_a (
      .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n),
      .io_dout(io_dout), .ef3(e3_a), .ef4(e4_a), .key_sel(sel_a), .keys1(k1_a), .keys2(k2_a));

   studio2_keypad #(.HOLD_W(20), .MIN_HOLD(100)) dut_b (
      .clk(clk), .reset(reset), .ps2_key(ps2_key), .io_out(io_out), .io_n(io_n),
      .io_dout(io_dout), .ef3(e3_b), .ef4(e4_b), .key_sel(sel_b), .keys1(k1_b), .keys2(k2_b));

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] kcode [20] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                              8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
   longint     m_hold [2] = '{0, 100};

   // Model: a key falls at max(release edge, press edge + MIN_HOLD).
   bit [19:0]  m_held [2];
   bit [19:0]  m_pend [2];
   longint     m_dead [2][20];
   bit         m_ef3 [2];
   bit         m_ef4 [2];
   logic [3:0] m_sel;
   bit         m_old, m_primed;
   longint     m_now = 0;

   function automatic int keyidx(input logic [7:0] c);
      for (int i = 0; i < 20; i++) if (kcode[i] == c) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_held[d] = '0;
         m_pend[d] = '0;
         m_ef3[d]  = 1'b0;
         m_ef4[d]  = 1'b0;
      end
      m_sel = 4'd0;
      m_old = 1'b0;
      m_primed = 1'b0;
   endtask

   task automatic model_edge();
      int idx;
      bit ev;
      if (reset) begin
         model_reset();
         m_now++;
         return;
      end
      for (int d = 0; d < 2; d++) begin
         m_ef3[d] = (m_sel <= 9) ? m_held[d][m_sel] : 1'b0;
         m_ef4[d] = (m_sel <= 9) ? m_held[d][int'(m_sel) + 10] : 1'b0;
      end
      ev  = m_primed && (ps2_key[10] != m_old);
      idx = (ev && !ps2_key[8]) ? keyidx(ps2_key[7:0]) : -1;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 20; k++) begin
            if (k == idx) begin
               if (ps2_key[9]) begin
                  m_held[d][k] = 1'b1;
                  m_pend[d][k] = 1'b0;
                  m_dead[d][k] = m_now + m_hold[d];
               end else if (m_held[d][k]) begin
                  if (m_now >= m_dead[d][k]) begin
                     m_held[d][k] = 1'b0;
                     m_pend[d][k] = 1'b0;
                  end else begin
                     m_pend[d][k] = 1'b1;
                  end
               end
            end else if (m_pend[d][k] && m_now >= m_dead[d][k]) begin
               m_held[d][k] = 1'b0;
               m_pend[d][k] = 1'b0;
            end
         end
      end
      if (io_out && io_n == 3'd2) m_sel = io_dout[3:0];
      m_old = ps2_key[10];
      m_primed = 1'b1;
      m_now++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, m_now);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_a_keys1"}, 32'(k1_a), 32'(m_held[0][9:0]));
      chk({tag, "_a_keys2"}, 32'(k2_a), 32'(m_held[0][19:10]));
      chk({tag, "_a_ef3"}, 32'(e3_a), 32'(m_ef3[0]));
      chk({tag, "_a_ef4"}, 32'(e4_a), 32'(m_ef4[0]));
      chk({tag, "_a_sel"}, 32'(sel_a), 32'(m_sel));
      chk({tag, "_b_keys1"}, 32'(k1_b), 32'(m_held[1][9:0]));
      chk({tag, "_b_keys2"}, 32'(k2_b), 32'(m_held[1][19:10]));
      chk({tag, "_b_ef3"}, 32'(e3_b), 32'(m_ef3[1]));
      chk({tag, "_b_ef4"}, 32'(e4_b), 32'(m_ef4[1]));
      chk({tag, "_b_sel"}, 32'(sel_b), 32'(m_sel));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all("step");
      io_out = 1'b0;
   endtask

   task automatic set_ps2(input bit press, input bit ext, input logic [7:0] code);
      ps2_key = {~ps2_key[10], press, ext, code};
   endtask

   task automatic set_out(input logic [2:0] n, input logic [7:0] d);
      io_out = 1'b1;
      io_n = n;
      io_dout = d;
   endtask

   // act: 0 idle, 1 press, 2 release, 3 extended press, 4 OUT (code = data)
   typedef struct {
      int         act;
      logic [7:0] code;
      logic [2:0] n;
      int         extra;
      logic [9:0] k1;
      logic [9:0] k2;
      logic [3:0] sel;
      logic       e3;
      logic       e4;
   } vec_t;

   vec_t tbl [18];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      longint p;
      tbl[0]  = '{4, 8'h05, 3'd2, 0, 10'h000, 10'h000, 4'h5, 1'b0, 1'b0};
      tbl[1]  = '{1, 8'h2E, 3'd0, 0, 10'h020, 10'h000, 4'h5, 1'b0, 1'b0};
      tbl[2]  = '{0, 8'h00, 3'd0, 0, 10'h020, 10'h000, 4'h5, 1'b1, 1'b0};
      tbl[3]  = '{2, 8'h2E, 3'd0, 0, 10'h000, 10'h000, 4'h5, 1'b1, 1'b0};
      tbl[4]  = '{0, 8'h00, 3'd0, 0, 10'h000, 10'h000, 4'h5, 1'b0, 1'b0};
      tbl[5]  = '{1, 8'h69, 3'd0, 1, 10'h000, 10'h002, 4'h5, 1'b0, 1'b0};
      tbl[6]  = '{4, 8'hF1, 3'd2, 0, 10'h000, 10'h002, 4'h1, 1'b0, 1'b0};
      tbl[7]  = '{0, 8'h00, 3'd0, 0, 10'h000, 10'h002, 4'h1, 1'b0, 1'b1};
      tbl[8]  = '{3, 8'h70, 3'd0, 1, 10'h000, 10'h002, 4'h1, 1'b0, 1'b1};
      tbl[9]  = '{1, 8'h1C, 3'd0, 1, 10'h000, 10'h002, 4'h1, 1'b0, 1'b1};
      tbl[10] = '{4, 8'h07, 3'd3, 1, 10'h000, 10'h002, 4'h1, 1'b0, 1'b1};
      tbl[11] = '{1, 8'h7D, 3'd0, 0, 10'h000, 10'h202, 4'h1, 1'b0, 1'b1};
      tbl[12] = '{4, 8'h0C, 3'd2, 0, 10'h000, 10'h202, 4'hC, 1'b0, 1'b1};
      tbl[13] = '{0, 8'h00, 3'd0, 0, 10'h000, 10'h202, 4'hC, 1'b0, 1'b0};
      tbl[14] = '{4, 8'h09, 3'd2, 0, 10'h000, 10'h202, 4'h9, 1'b0, 1'b0};
      tbl[15] = '{0, 8'h00, 3'd0, 0, 10'h000, 10'h202, 4'h9, 1'b0, 1'b1};
      tbl[16] = '{2, 8'h69, 3'd0, 0, 10'h000, 10'h200, 4'h9, 1'b0, 1'b1};
      tbl[17] = '{2, 8'h7D, 3'd0, 1, 10'h000, 10'h000, 4'h9, 1'b0, 1'b0};

      // Reset with the toggle bit already high: releasing reset must not create an event.
      reset = 1'b1;
      ps2_key = 11'h400;
      io_out = 1'b0;
      io_n = 3'd0;
      io_dout = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_keys1", 32'(k1_a | k1_b), 32'h0);
      chk("rst_keys2", 32'(k2_a | k2_b), 32'h0);
      chk("rst_ef", 32'({e3_a, e4_a, e3_b, e4_b}), 32'h0);
      chk("rst_sel", 32'({sel_a, sel_b}), 32'h0);
      reset = 1'b0;
      repeat (10) step();
      chk("prime_keys", 32'({k1_a, k2_a, k1_b, k2_b}), 32'h0);
      chk("prime_ef", 32'({e3_a, e4_a, e3_b, e4_b}), 32'h0);

      // Vector table, expectations for the MIN_HOLD=0 instance.
      for (int i = 0; i < 18; i++) begin
         case (tbl[i].act)
            1: set_ps2(1'b1, 1'b0, tbl[i].code);
            2: set_ps2(1'b0, 1'b0, tbl[i].code);
            3: set_ps2(1'b1, 1'b1, tbl[i].code);
            4: set_out(tbl[i].n, tbl[i].code);
            default: ;
         endcase
         step();
         for (int j = 0; j < tbl[i].extra; j++) step();
         chk($sformatf("vec%0d_keys1", i), 32'(k1_a), 32'(tbl[i].k1));
         chk($sformatf("vec%0d_keys2", i), 32'(k2_a), 32'(tbl[i].k2));
         chk($sformatf("vec%0d_sel", i), 32'(sel_a), 32'(tbl[i].sel));
         chk($sformatf("vec%0d_ef3", i), 32'(e3_a), 32'(tbl[i].e3));
         chk($sformatf("vec%0d_ef4", i), 32'(e4_a), 32'(tbl[i].e4));
      end

      // All 20 keys held: out-of-range select forces both flags low.
      for (int i = 0; i < 20; i++) begin
         set_ps2(1'b1, 1'b0, kcode[i]);
         step();
      end
      set_out(3'd2, 8'h0C);
      step();
      step();
      chk("allheld_selC_ef", 32'({e3_a, e4_a}), 32'h0);
      set_out(3'd2, 8'hF3);
      step();
      chk("allheld_sel3", 32'(sel_a), 32'h3);
      step();
      chk("allheld_sel3_ef", 32'({e3_a, e4_a}), 32'h3);
      set_ps2(1'b0, 1'b0, kcode[3]);
      step();
      step();
      chk("rel3_ef", 32'({e3_a, e4_a}), 32'h1);
      for (int i = 0; i < 20; i++) begin
         set_ps2(1'b0, 1'b0, kcode[i]);
         step();
      end
      repeat (150) step();

      // Minimum hold on the MIN_HOLD=100 instance: release at P+10 falls at P+100.
      set_out(3'd2, 8'h01);
      step();
      chk("hold_pre", 32'(k2_b[1]), 32'h0);
      p = m_now;
      set_ps2(1'b1, 1'b0, 8'h69);
      step();
      repeat (9) step();
      set_ps2(1'b0, 1'b0, 8'h69);
      step();
      while (m_now < p + 100) step();
      chk("hold_p99_key", 32'(k2_b[1]), 32'h1);
      chk("hold_p99_ef4", 32'(e4_b), 32'h1);
      step();
      chk("hold_p100_key", 32'(k2_b[1]), 32'h0);
      chk("hold_p100_ef4", 32'(e4_b), 32'h1);
      step();
      chk("hold_p101_ef4", 32'(e4_b), 32'h0);

      // Repress while the release is pending cancels the scheduled drop.
      p = m_now;
      set_ps2(1'b1, 1'b0, 8'h16);
      step();
      repeat (9) step();
      set_ps2(1'b0, 1'b0, 8'h16);
      step();
      while (m_now < p + 50) step();
      set_ps2(1'b1, 1'b0, 8'h16);
      step();
      while (m_now < p + 130) step();
      chk("repress_key", 32'(k1_b[1]), 32'h1);
      set_ps2(1'b0, 1'b0, 8'h16);
      step();
      repeat (30) step();

      // Randomised traffic: mapped, unmapped and extended codes plus select writes.
      repeat (3000) begin
         if ($urandom_range(0, 3) == 0) begin
            int r;
            r = $urandom_range(0, 23);
            if (r < 20)      set_ps2(1'($urandom_range(0, 1)), 1'b0, kcode[r]);
            else if (r < 22) set_ps2(1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
            else             set_ps2(1'($urandom_range(0, 1)), 1'b1, kcode[$urandom_range(0, 19)]);
         end
         if ($urandom_range(0, 9) == 0) begin
            set_out(($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd2, 8'($urandom));
         end
         step();
      end

      // Asynchronous reset while keys are held, then a stale release is harmless.
      set_ps2(1'b1, 1'b0, 8'h45);
      step();
      set_ps2(1'b1, 1'b0, 8'h70);
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("arst_keys", 32'({k1_a, k2_a, k1_b, k2_b}), 32'h0);
      chk("arst_ef_sel", 32'({e3_a, e4_a, e3_b, e4_b, sel_a, sel_b}), 32'h0);
      model_reset();
      step();
      step();
      reset = 1'b0;
      step();
      set_ps2(1'b0, 1'b0, 8'h45);
      step();
      step();
      chk("post_rst_release", 32'({k1_a, k2_a, k1_b, k2_b}), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
